ram_capture_writer: RTL and testbench

- Upstream feeder of the BRAM debug readback stage.
- Accepts a stream of 16-bit audio samples and packs two samples per 32-bit word.
- Writes the words to BRAM port A at byte addresses 0, 4, 8, …
- After DEPTH_WORDS words are written, pulses debug_start so the port-B readback stage begins its sequential dump.

---
 rtl/ram_capture_writer.sv | 133 +++++++++++++
 tb/tb_ram_capture_writer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_capture_writer.sv
// Packs pairs of 16-bit audio samples into 32-bit words and writes them to BRAM port A,
// then pulses debug_start once a full capture of DEPTH_WORDS words has been written.
module ram_capture_writer #(
    parameter int          SAMPLE_W    = 16,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int          ADDR_W      = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  capture_en,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   sample_data,
    output logic                  sample_ready,
    output logic                  ena,
    output logic [3:0]            wea,
    output logic [ADDR_W-1:0]     addra,
    output logic [2*SAMPLE_W-1:0] dina,
    output logic                  rsta,
    output logic [ADDR_W-1:0]     word_count,
    output logic                  capture_done,
    output logic                  debug_start
);

    typedef enum logic [1:0] {IDLE, CAP_LO, CAP_HI, DONE} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

    state_t                state_q, state_d;
    logic [SAMPLE_W-1:0]   lo_q, lo_d;
    logic                  ena_q, ena_d;
    logic [3:0]            wea_q, wea_d;
    logic [ADDR_W-1:0]     addra_q, addra_d;
    logic [2*SAMPLE_W-1:0] dina_q, dina_d;
    logic [ADDR_W-1:0]     word_count_q, word_count_d;
    logic                  capture_done_q, capture_done_d;
    logic                  debug_start_q, debug_start_d;
    logic                  sample_ready_q, sample_ready_d;
    logic                  accept;

    assign accept = sample_valid && sample_ready_q && capture_en;

    always_comb begin
        state_d        = state_q;
        lo_d           = lo_q;
        ena_d          = 1'b0;
        wea_d          = 4'h0;
        addra_d        = addra_q;
        dina_d         = dina_q;
        word_count_d   = word_count_q;
        capture_done_d = capture_done_q;
        debug_start_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (capture_en) begin
                    state_d      = CAP_LO;
                    word_count_d = '0;
                end
            end
            CAP_LO: begin
                if (!capture_en) begin
                    state_d = IDLE;
                end else if (accept) begin
                    lo_d    = sample_data;
                    state_d = CAP_HI;
                end
            end
            CAP_HI: begin
                // Abort takes priority over a coincident sample: the half word is dropped.
                if (!capture_en) begin
                    state_d = IDLE;
                end else if (accept) begin
                    ena_d        = 1'b1;
                    wea_d        = 4'hF;
                    dina_d       = {sample_data, lo_q};
                    addra_d      = word_count_q << 2;
                    word_count_d = word_count_q + ADDR_W'(1);
                    state_d      = (word_count_q + ADDR_W'(1) == DEPTH_L) ? DONE : CAP_LO;
                end
            end
            DONE: begin
                // ena_q is high only in the first DONE cycle (the final strobe), so it marks completion.
                debug_start_d = ena_q;
                if (!capture_en) begin
                    state_d        = IDLE;
                    capture_done_d = 1'b0;
                end else if (ena_q) begin
                    capture_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        sample_ready_d = (state_d == CAP_LO) || (state_d == CAP_HI);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            lo_q           <= '0;
            ena_q          <= 1'b0;
            wea_q          <= 4'h0;
            addra_q        <= '0;
            dina_q         <= '0;
            word_count_q   <= '0;
            capture_done_q <= 1'b0;
            debug_start_q  <= 1'b0;
            sample_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lo_q           <= lo_d;
            ena_q          <= ena_d;
            wea_q          <= wea_d;
            addra_q        <= addra_d;
            dina_q         <= dina_d;
            word_count_q   <= word_count_d;
            capture_done_q <= capture_done_d;
            debug_start_q  <= debug_start_d;
            sample_ready_q <= sample_ready_d;
        end
    end

    assign sample_ready = sample_ready_q;
    assign ena          = ena_q;
    assign wea          = wea_q;
    assign addra        = addra_q;
    assign dina         = dina_q;
    assign rsta         = 1'b0;
    assign word_count   = word_count_q;
    assign capture_done = capture_done_q;
    assign debug_start  = debug_start_q;

endmodule

// File: tb/tb_ram_capture_writer.sv
// Bench for ram_capture_writer with DEPTH_WORDS = 4: vector table, hand sequences for reset
// corner cases, and randomized gapped captures checked against a word-level scoreboard.
module tb_ram_capture_writer;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_en = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_ready, ena, rsta, capture_done, debug_start;
    logic [3:0]  wea;
    logic [31:0] addra, dina, word_count;

    ram_capture_writer #(.SAMPLE_W(16), .DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .capture_en(capture_en),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(sample_ready), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .rsta(rsta), .word_count(word_count),
        .capture_done(capture_done), .debug_start(debug_start)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        en;
        logic        valid;
        logic [15:0] data;
        logic [104:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    function automatic logic [104:0] outs();
        return {rsta, ena, wea, addra, dina, word_count, sample_ready, capture_done, debug_start};
    endfunction

    function automatic vec_t mkv(logic en, logic valid, logic [15:0] data, logic e_ena,
                                 logic [31:0] e_addr, logic [31:0] e_dina, logic [31:0] e_wc,
                                 logic e_rdy, logic e_done, logic e_ds);
        vec_t v;
        v.en    = en;
        v.valid = valid;
        v.data  = data;
        v.exp   = {1'b0, e_ena, (e_ena ? 4'hF : 4'h0), e_addr, e_dina, e_wc, e_rdy, e_done, e_ds};
        return v;
    endfunction

    task automatic check_outs(string name, logic [104:0] exp);
        logic [104:0] act;
        act = outs();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {rsta,ena,wea,addra,dina,wc,rdy,done,ds}=%h required %h", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    vec_t vecs [0:22];

    initial begin
        // Full capture 0x0001..0x0008, samples in DONE, leave, then an aborted and a re-armed capture.
        vecs[0]  = mkv(1, 0, 16'h0000, 0, 32'h0, 32'h0,        0, 1, 0, 0);
        vecs[1]  = mkv(1, 1, 16'h0001, 0, 32'h0, 32'h0,        0, 1, 0, 0);
        vecs[2]  = mkv(1, 1, 16'h0002, 1, 32'h0, 32'h00020001, 1, 1, 0, 0);
        vecs[3]  = mkv(1, 1, 16'h0003, 0, 32'h0, 32'h00020001, 1, 1, 0, 0);
        vecs[4]  = mkv(1, 1, 16'h0004, 1, 32'h4, 32'h00040003, 2, 1, 0, 0);
        vecs[5]  = mkv(1, 1, 16'h0005, 0, 32'h4, 32'h00040003, 2, 1, 0, 0);
        vecs[6]  = mkv(1, 1, 16'h0006, 1, 32'h8, 32'h00060005, 3, 1, 0, 0);
        vecs[7]  = mkv(1, 1, 16'h0007, 0, 32'h8, 32'h00060005, 3, 1, 0, 0);
        vecs[8]  = mkv(1, 1, 16'h0008, 1, 32'hC, 32'h00080007, 4, 0, 0, 0);
        vecs[9]  = mkv(1, 1, 16'h0009, 0, 32'hC, 32'h00080007, 4, 0, 1, 1);
        vecs[10] = mkv(1, 1, 16'h000A, 0, 32'hC, 32'h00080007, 4, 0, 1, 0);
        vecs[11] = mkv(1, 1, 16'h000B, 0, 32'hC, 32'h00080007, 4, 0, 1, 0);
        vecs[12] = mkv(0, 0, 16'h0000, 0, 32'hC, 32'h00080007, 4, 0, 0, 0);
        vecs[13] = mkv(1, 0, 16'h0000, 0, 32'hC, 32'h00080007, 0, 1, 0, 0);
        vecs[14] = mkv(1, 1, 16'h00A1, 0, 32'hC, 32'h00080007, 0, 1, 0, 0);
        vecs[15] = mkv(1, 1, 16'h00A2, 1, 32'h0, 32'h00A200A1, 1, 1, 0, 0);
        vecs[16] = mkv(1, 1, 16'h00A3, 0, 32'h0, 32'h00A200A1, 1, 1, 0, 0);
        vecs[17] = mkv(0, 1, 16'h00A4, 0, 32'h0, 32'h00A200A1, 1, 0, 0, 0);
        vecs[18] = mkv(0, 0, 16'h0000, 0, 32'h0, 32'h00A200A1, 1, 0, 0, 0);
        vecs[19] = mkv(1, 0, 16'h0000, 0, 32'h0, 32'h00A200A1, 0, 1, 0, 0);
        vecs[20] = mkv(1, 1, 16'h00B1, 0, 32'h0, 32'h00A200A1, 0, 1, 0, 0);
        vecs[21] = mkv(1, 1, 16'h00B2, 1, 32'h0, 32'h00B200B1, 1, 1, 0, 0);
        vecs[22] = mkv(0, 0, 16'h0000, 0, 32'h0, 32'h00B200B1, 1, 0, 0, 0);

        // Reset held with inputs active.
        rst_n = 1'b0; capture_en = 1'b1; sample_valid = 1'b1; sample_data = 16'hFFFF;
        repeat (3) tick();
        check_outs("reset_hold", '0);
        rst_n = 1'b1; capture_en = 1'b0; sample_valid = 1'b0; sample_data = '0;
        tick();
        check_outs("idle_after_reset", '0);

        for (int i = 0; i <= 22; i++) begin
            capture_en   = vecs[i].en;
            sample_valid = vecs[i].valid;
            sample_data  = vecs[i].data;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset arriving during a write strobe drops ena at that edge.
        capture_en = 1'b1; sample_valid = 1'b0;
        tick();
        sample_valid = 1'b1; sample_data = 16'h0C01;
        tick();
        sample_data = 16'h0C02;
        tick();
        check1("strobe_before_reset", {31'd0, ena}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_outs("reset_mid_strobe", '0);

        // Reset going low between edges must not affect outputs before the next edge.
        rst_n = 1'b1; sample_valid = 1'b0;
        tick();
        check1("ready_armed", {31'd0, sample_ready}, 32'd1);
        @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        check1("ready_between_edges", {31'd0, sample_ready}, 32'd1);
        tick();
        check_outs("reset_at_edge", '0);
        rst_n = 1'b1; capture_en = 1'b0;
        tick();

        // Randomized gapped captures against a word-level scoreboard.
        for (int r = 0; r < 3; r++) begin
            word_t       exp_q[$];
            word_t       w;
            int          acc;
            int          strobes;
            int          ds_cnt;
            int          last_strobe;
            logic        m_ready;
            logic        acc_now;
            logic        want_strobe;
            logic [15:0] lo;

            acc = 0; strobes = 0; ds_cnt = 0; last_strobe = -10; lo = '0;
            capture_en = 1'b0; sample_valid = 1'b0;
            tick(); tick();
            capture_en = 1'b1;
            tick();
            m_ready = 1'b1;
            for (int cyc = 0; cyc < 200; cyc++) begin
                sample_valid = ($urandom_range(0, 2) != 0);
                sample_data  = (r == 0) ? 16'(acc + 1) : 16'($urandom);
                check1($sformatf("run%0d_ready_c%0d", r, cyc), {31'd0, sample_ready}, {31'd0, m_ready});
                acc_now     = sample_valid && m_ready;
                want_strobe = 1'b0;
                if (acc_now) begin
                    if (acc % 2 == 0) begin
                        lo = sample_data;
                    end else begin
                        w.addr = 32'((acc / 2) * 4);
                        w.data = {sample_data, lo};
                        exp_q.push_back(w);
                        want_strobe = 1'b1;
                    end
                    acc++;
                end
                tick();
                m_ready = (acc < 2 * DEPTH);
                check1($sformatf("run%0d_ena_c%0d", r, cyc), {31'd0, ena}, {31'd0, want_strobe});
                if (ena && exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check1($sformatf("run%0d_addra_w%0d", r, strobes), addra, w.addr);
                    check1($sformatf("run%0d_dina_w%0d", r, strobes), dina, w.data);
                    check1($sformatf("run%0d_wea_w%0d", r, strobes), {28'd0, wea}, 32'hF);
                    strobes++;
                    last_strobe = cyc;
                end
                if (debug_start) begin
                    ds_cnt++;
                    check1($sformatf("run%0d_ds_delay", r), 32'(cyc - last_strobe), 32'd1);
                    check1($sformatf("run%0d_ds_words", r), 32'(strobes), 32'(DEPTH));
                end
            end
            check1($sformatf("run%0d_strobes", r), 32'(strobes), 32'(DEPTH));
            check1($sformatf("run%0d_ds_count", r), 32'(ds_cnt), 32'd1);
            check1($sformatf("run%0d_leftover", r), 32'(exp_q.size()), 32'd0);
            check1($sformatf("run%0d_done", r), {31'd0, capture_done}, 32'd1);
            check1($sformatf("run%0d_wc", r), word_count, 32'(DEPTH));
            $display("run %0d: %0d words written, %0d debug_start pulses", r, strobes, ds_cnt);
        end

        capture_en = 1'b0; sample_valid = 1'b0;
        tick();
        check1("done_cleared", {31'd0, capture_done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
